hpi_target_model: RTL and testbench
===================================

# hpi_target_model

Synthesizable responder for the 16-bit OTG host-port interface (HPI) that the Nios II SoC drives through its `otg_hpi_*` PIO exports. It emulates the target side of the EZ-OTG host port:
- DATA, MAILBOX, ADDRESS and STATUS registers;
- an auto-incrementing window into an on-chip word memory;
- a device-side port so on-chip logic can post keyboard reports and mailbox messages.

It lets the USB keyboard driver run in simulation and on boards without the physical controller.

## Interface
Parameters:
- `MEM_AW`, 12: word-address width of backing memory (2^MEM_AW 16-bit words).

Ports:
- `clk_clk`  in  1  system clock; all HPI inputs are synchronous to it.
- `reset_reset_n`  in  1  asynchronous, active-low reset.
- `hpi_reset_n`  in  1  initiator soft reset, active-low, sampled synchronously.
- `hpi_address`  in  2  register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS.
- `hpi_cs_n`, `hpi_r_n`, `hpi_w_n`  in  1 each  active-low chip select, read strobe and write strobe.
- `hpi_data_in`  in  16  write data from initiator.
- `hpi_data_out`  out  16  registered read data to initiator.
- `hpi_int`  out  1  high while the outbound mailbox is full.
- `dev_mem_we`, `dev_mem_addr[MEM_AW-1:0]`, `dev_mem_wdata[15:0]`  in  device-side memory write.
- `dev_mbx_wr`, `dev_mbx_wdata[15:0]`  in  device posts an outbound mailbox word.
- `dev_mbx_valid`  out  1  inbound mailbox full.
- `dev_mbx_rdata`  out  16  inbound mailbox contents.
- `dev_mbx_ack`  in  1  device consumes the inbound mailbox.

## Operation
Access detection:
- Read access = `!hpi_cs_n & !hpi_r_n & hpi_w_n`; write access = `!hpi_cs_n & !hpi_w_n & hpi_r_n`.
- Exactly one action occurs per access, on its first cycle. The FSM then waits for release, i.e. the access condition goes false.
- Both strobes low is illegal: no action, no state change.

Address register:
- 16-bit byte address; the word index is `addr[MEM_AW:1]`, higher bits alias.
- Every DATA access adds 2, wrapping 0xFFFE -> 0x0000.

Writes:
- DATA: `mem[addr] <= data_in`, then addr += 2.
- MAILBOX: `mbx_in <= data_in`, `mbx_in_full <= 1`. If already full, also set the sticky `mbx_in_ovf`.
- ADDRESS: `addr <= data_in`.
- STATUS: ignored.

Reads (`hpi_data_out` holds its value until the next read):
- DATA: memory read, then addr += 2.
- MAILBOX: returns `mbx_out`, clears `mbx_out_full`.
- ADDRESS: returns `addr`.
- STATUS: returns `{7'b0, mbx_in_full, 6'b0, mbx_in_ovf, mbx_out_full}`, clears `mbx_in_ovf`.

Device side:
- `dev_mbx_wr` loads `mbx_out` and sets `mbx_out_full`.
- `dev_mbx_ack` clears `mbx_in_full`.
- `dev_mbx_valid = mbx_in_full`; `dev_mbx_rdata = mbx_in`; `hpi_int = mbx_out_full`.

FSM:
- IDLE -> MEM_RD on a DATA read; MEM_RD -> RELEASE.
- IDLE -> RELEASE on any other legal access.
- RELEASE -> IDLE when the access condition goes false.

Collisions:
- Host DATA write and `dev_mem_we` to the same word in the same cycle: the host value is stored.
- `dev_mbx_wr` in the same cycle as a host MAILBOX read: the read returns the old value, the new value is stored, `mbx_out_full` stays 1.
- `dev_mbx_ack` in the same cycle as a host MAILBOX write: the new value is stored, `mbx_in_full` stays 1.

## Timing
Reset values (both `reset_reset_n` low and `hpi_reset_n` low):
- `hpi_data_out`=0, `hpi_int`=0, `dev_mbx_valid`=0, `dev_mbx_rdata`=0.
- addr=0, all flags 0, FSM in IDLE.
- Memory contents are not reset.

Latency (access first sampled at cycle T):
- Register reads: `hpi_data_out` valid at T+1.
- DATA reads: `hpi_data_out` valid at T+2 (synchronous RAM).
- Writes: state updated at T+1.
- Back-to-back accesses need at least 1 cycle of release between them. The initiator (PIO, software-paced) always exceeds this.

`hpi_reset_n` low mid-access aborts it: no address increment, no flag change from that access.

## Structure
- Package `hpi_pkg`:
  - register-select constants (`HPI_DATA`=0, `HPI_MAILBOX`=1, `HPI_ADDRESS`=2, `HPI_STATUS`=3);
  - STATUS bit positions (`ST_MBX_OUT`=0, `ST_MBX_OVF`=1, `ST_MBX_IN`=8);
  - FSM state enum (IDLE, MEM_RD, RELEASE).
- Sub-module `hpi_target_ram`: simple dual-port memory.
  - Port A: host read/write with synchronous read.
  - Port B: device write-only.
  - Same-word collision resolved to port A.

## Test plan
- Write ADDRESS=0x0100; write DATA 0x1111, 0x2222 -> ADDRESS read returns 0x0104; `mem[0x80]`=0x1111, `mem[0x81]`=0x2222.
- Write ADDRESS=0xFFFE; read DATA twice -> returns `mem[(0xFFFE>>1) & mask]` then `mem[0]`; ADDRESS reads 0x0002.
- `dev_mbx_wr` 0xBEEF -> `hpi_int`=1 and STATUS bit0=1; host MAILBOX read returns 0xBEEF -> `hpi_int`=0 at T+1.
- Host MAILBOX writes 0x0001 then 0x0002 without ack -> `dev_mbx_rdata`=0x0002, STATUS=0x0102; a second STATUS read returns 0x0100.
- Hold `hpi_r_n` low on DATA for 20 cycles -> address increments exactly once. Both strobes low -> no state change.
- Assert `hpi_reset_n` during a DATA read at T+1 -> addr=0, `hpi_data_out`=0, flags 0, memory preserved.

Source files
------------

// File: rtl/hpi_pkg.sv
// -----------------------------------------------------------------------------
// hpi_pkg
// Shared definitions for the HPI target model: the register-select codes,
// the bit positions inside the STATUS word, the access FSM state type and a
// helper that assembles the STATUS word from the mailbox flags.
// -----------------------------------------------------------------------------
package hpi_pkg;

   // Width of every HPI register and memory word
   localparam int DATA_W = 16;

   // Register-select codes driven on hpi_address
   localparam logic [1:0] HPI_DATA    = 2'd0;
   localparam logic [1:0] HPI_MAILBOX = 2'd1;
   localparam logic [1:0] HPI_ADDRESS = 2'd2;
   localparam logic [1:0] HPI_STATUS  = 2'd3;

   // Bit positions inside the STATUS word
   localparam int ST_MBX_OUT = 0;
   localparam int ST_MBX_OVF = 1;
   localparam int ST_MBX_IN  = 8;

   // Access FSM: one action on the first cycle of an access, then wait for
   // the initiator to drop its strobes before accepting another one
   typedef enum logic [1:0] {
      IDLE,
      MEM_RD,
      RELEASE
   } hpi_state_e;

   // Builds the STATUS word; all bits not named above read as zero
   function automatic logic [DATA_W-1:0] statusWord(input logic mbxInFull,
                                                    input logic mbxInOvf,
                                                    input logic mbxOutFull);
      logic [DATA_W-1:0] word;
      word             = '0;
      word[ST_MBX_IN]  = mbxInFull;
      word[ST_MBX_OVF] = mbxInOvf;
      word[ST_MBX_OUT] = mbxOutFull;
      return word;
   endfunction

endpackage

// File: rtl/hpi_target_ram.sv
// -----------------------------------------------------------------------------
// hpi_target_ram
// Simple dual-port word memory behind the HPI DATA register.
//   clk_i      : clock
//   aEn_i      : port A access enable (read when aWe_i is low)
//   aWe_i      : port A write enable
//   aAddr_i    : port A word address
//   aWdata_i   : port A write data
//   aRdata_o   : port A registered read data (valid the cycle after aEn_i)
//   bWe_i      : port B (device) write enable
//   bAddr_i    : port B word address
//   bWdata_i   : port B write data
// Contents are never reset.
// -----------------------------------------------------------------------------
module hpi_target_ram
   import hpi_pkg::*;
#(
   parameter int AW = 12
) (
   input  logic              clk_i,
   input  logic              aEn_i,
   input  logic              aWe_i,
   input  logic [AW-1:0]     aAddr_i,
   input  logic [DATA_W-1:0] aWdata_i,
   output logic [DATA_W-1:0] aRdata_o,
   input  logic              bWe_i,
   input  logic [AW-1:0]     bAddr_i,
   input  logic [DATA_W-1:0] bWdata_i
);

   logic [DATA_W-1:0] mem [2**AW];
   logic [DATA_W-1:0] aRdata_q;

   // Both write ports plus the synchronous port-A read. When both ports hit
   // the same word in one cycle the device write is dropped so the host
   // value is the one that lands.
   always_ff @(posedge clk_i) begin
      if (bWe_i && !(aWe_i && (aAddr_i == bAddr_i))) begin
         mem[bAddr_i] <= bWdata_i;
      end
      if (aWe_i) begin
         mem[aAddr_i] <= aWdata_i;
      end
      if (aEn_i && !aWe_i) begin
         aRdata_q <= mem[aAddr_i];
      end
   end

   assign aRdata_o = aRdata_q;

endmodule

// File: rtl/hpi_target_model.sv
// -----------------------------------------------------------------------------
// hpi_target_model
// Target side of the 16-bit OTG host-port interface: DATA / MAILBOX /
// ADDRESS / STATUS registers, an auto-incrementing window into on-chip word
// memory, and a device-side port for posting reports and mailbox words.
//   clk_clk            : system clock, all HPI inputs synchronous to it
//   reset_reset_n      : asynchronous active-low reset
//   hpi_reset_n        : initiator soft reset, active-low, synchronous
//   hpi_address        : register select (DATA/MAILBOX/ADDRESS/STATUS)
//   hpi_cs_n/r_n/w_n   : active-low chip select, read and write strobes
//   hpi_data_in        : write data from the initiator
//   hpi_data_out       : registered read data, held until the next read
//   hpi_int            : high while the outbound mailbox is full
//   dev_mem_*          : device-side memory write port
//   dev_mbx_wr/wdata   : device posts an outbound mailbox word
//   dev_mbx_valid/rdata: inbound mailbox full flag and contents
//   dev_mbx_ack        : device consumes the inbound mailbox
// -----------------------------------------------------------------------------
module hpi_target_model
   import hpi_pkg::*;
#(
   parameter int MEM_AW = 12
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic              hpi_reset_n,
   input  logic [1:0]        hpi_address,
   input  logic              hpi_cs_n,
   input  logic              hpi_r_n,
   input  logic              hpi_w_n,
   input  logic [DATA_W-1:0] hpi_data_in,
   output logic [DATA_W-1:0] hpi_data_out,
   output logic              hpi_int,
   input  logic              dev_mem_we,
   input  logic [MEM_AW-1:0] dev_mem_addr,
   input  logic [DATA_W-1:0] dev_mem_wdata,
   input  logic              dev_mbx_wr,
   input  logic [DATA_W-1:0] dev_mbx_wdata,
   output logic              dev_mbx_valid,
   output logic [DATA_W-1:0] dev_mbx_rdata,
   input  logic              dev_mbx_ack
);

   hpi_state_e        state_q,      state_d;
   logic [15:0]       addr_q,       addr_d;
   logic [DATA_W-1:0] dataOut_q,    dataOut_d;
   logic [DATA_W-1:0] mbxIn_q,      mbxIn_d;
   logic              mbxInFull_q,  mbxInFull_d;
   logic              mbxInOvf_q,   mbxInOvf_d;
   logic [DATA_W-1:0] mbxOut_q,     mbxOut_d;
   logic              mbxOutFull_q, mbxOutFull_d;

   logic              rdAccess;
   logic              wrAccess;
   logic              hostMbxWrite;
   logic              ramEn;
   logic              ramWe;
   logic [DATA_W-1:0] ramRdata;

   // Both strobes low matches neither term, so an illegal access is ignored
   assign rdAccess = !hpi_cs_n && !hpi_r_n &&  hpi_w_n;
   assign wrAccess = !hpi_cs_n && !hpi_w_n &&  hpi_r_n;

   // Next-state logic: the host action fires only from IDLE, so holding a
   // strobe for many cycles still performs exactly one action. Device-side
   // mailbox events are applied after the host action so that a device post
   // wins over a host mailbox read clearing the flag, while a host mailbox
   // write wins over a device acknowledge.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      dataOut_d    = dataOut_q;
      mbxIn_d      = mbxIn_q;
      mbxInFull_d  = mbxInFull_q;
      mbxInOvf_d   = mbxInOvf_q;
      mbxOut_d     = mbxOut_q;
      mbxOutFull_d = mbxOutFull_q;
      hostMbxWrite = 1'b0;
      ramEn        = 1'b0;
      ramWe        = 1'b0;

      case (state_q)
         IDLE: begin
            if (rdAccess) begin
               state_d = RELEASE;
               case (hpi_address)
                  HPI_DATA: begin
                     ramEn   = 1'b1;
                     addr_d  = addr_q + 16'd2;
                     state_d = MEM_RD;
                  end
                  HPI_MAILBOX: begin
                     dataOut_d    = mbxOut_q;
                     mbxOutFull_d = 1'b0;
                  end
                  HPI_ADDRESS: begin
                     dataOut_d = addr_q;
                  end
                  default: begin
                     dataOut_d  = statusWord(mbxInFull_q, mbxInOvf_q, mbxOutFull_q);
                     mbxInOvf_d = 1'b0;
                  end
               endcase
            end else if (wrAccess) begin
               state_d = RELEASE;
               case (hpi_address)
                  HPI_DATA: begin
                     ramEn  = 1'b1;
                     ramWe  = 1'b1;
                     addr_d = addr_q + 16'd2;
                  end
                  HPI_MAILBOX: begin
                     hostMbxWrite = 1'b1;
                     mbxIn_d      = hpi_data_in;
                     mbxInFull_d  = 1'b1;
                     if (mbxInFull_q) begin
                        mbxInOvf_d = 1'b1;
                     end
                  end
                  HPI_ADDRESS: begin
                     addr_d = hpi_data_in;
                  end
                  default: begin
                  end
               endcase
            end
         end
         MEM_RD: begin
            dataOut_d = ramRdata;
            state_d   = RELEASE;
         end
         default: begin
            if (!rdAccess && !wrAccess) begin
               state_d = IDLE;
            end
         end
      endcase

      if (dev_mbx_wr) begin
         mbxOut_d     = dev_mbx_wdata;
         mbxOutFull_d = 1'b1;
      end
      if (dev_mbx_ack && !hostMbxWrite) begin
         mbxInFull_d = 1'b0;
      end
   end

   // State registers. The soft reset clears everything exactly like the
   // hard reset, which also discards whatever the aborted access was doing.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         dataOut_q    <= '0;
         mbxIn_q      <= '0;
         mbxInFull_q  <= 1'b0;
         mbxInOvf_q   <= 1'b0;
         mbxOut_q     <= '0;
         mbxOutFull_q <= 1'b0;
      end else if (!hpi_reset_n) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         dataOut_q    <= '0;
         mbxIn_q      <= '0;
         mbxInFull_q  <= 1'b0;
         mbxInOvf_q   <= 1'b0;
         mbxOut_q     <= '0;
         mbxOutFull_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         dataOut_q    <= dataOut_d;
         mbxIn_q      <= mbxIn_d;
         mbxInFull_q  <= mbxInFull_d;
         mbxInOvf_q   <= mbxInOvf_d;
         mbxOut_q     <= mbxOut_d;
         mbxOutFull_q <= mbxOutFull_d;
      end
   end

   // Host writes are suppressed under soft reset so an aborted access
   // leaves memory untouched; device writes always go through.
   hpi_target_ram #(
      .AW (MEM_AW)
   ) uRam (
      .clk_i    (clk_clk),
      .aEn_i    (ramEn && hpi_reset_n),
      .aWe_i    (ramWe && hpi_reset_n),
      .aAddr_i  (addr_q[MEM_AW:1]),
      .aWdata_i (hpi_data_in),
      .aRdata_o (ramRdata),
      .bWe_i    (dev_mem_we),
      .bAddr_i  (dev_mem_addr),
      .bWdata_i (dev_mem_wdata)
   );

   assign hpi_data_out  = dataOut_q;
   assign hpi_int       = mbxOutFull_q;
   assign dev_mbx_valid = mbxInFull_q;
   assign dev_mbx_rdata = mbxIn_q;

endmodule

// File: tb/tb_hpi_target_model.sv
// -----------------------------------------------------------------------------
// tb_hpi_target_model
// Directed bench for hpi_target_model. Inputs change on the falling clock
// edge and outputs are sampled on the falling edge, away from the active edge.
// -----------------------------------------------------------------------------
module tb_hpi_target_model;
   import hpi_pkg::*;

   localparam int MEM_AW = 12;

   logic              clk_clk = 1'b0;
   logic              reset_reset_n;
   logic              hpi_reset_n;
   logic [1:0]        hpi_address;
   logic              hpi_cs_n;
   logic              hpi_r_n;
   logic              hpi_w_n;
   logic [15:0]       hpi_data_in;
   logic [15:0]       hpi_data_out;
   logic              hpi_int;
   logic              dev_mem_we;
   logic [MEM_AW-1:0] dev_mem_addr;
   logic [15:0]       dev_mem_wdata;
   logic              dev_mbx_wr;
   logic [15:0]       dev_mbx_wdata;
   logic              dev_mbx_valid;
   logic [15:0]       dev_mbx_rdata;
   logic              dev_mbx_ack;

   int totalChecks = 0;
   int badChecks   = 0;
   logic [15:0] rd;

   hpi_target_model #(.MEM_AW(MEM_AW)) dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .hpi_reset_n   (hpi_reset_n),
      .hpi_address   (hpi_address),
      .hpi_cs_n      (hpi_cs_n),
      .hpi_r_n       (hpi_r_n),
      .hpi_w_n       (hpi_w_n),
      .hpi_data_in   (hpi_data_in),
      .hpi_data_out  (hpi_data_out),
      .hpi_int       (hpi_int),
      .dev_mem_we    (dev_mem_we),
      .dev_mem_addr  (dev_mem_addr),
      .dev_mem_wdata (dev_mem_wdata),
      .dev_mbx_wr    (dev_mbx_wr),
      .dev_mbx_wdata (dev_mbx_wdata),
      .dev_mbx_valid (dev_mbx_valid),
      .dev_mbx_rdata (dev_mbx_rdata),
      .dev_mbx_ack   (dev_mbx_ack)
   );

   // 100 MHz-style free-running clock
   always #5 clk_clk = ~clk_clk;

   // Compares one observed value against its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      totalChecks++;
      if (observed !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // Drives the host strobes, select and write data
   task automatic applyStimulus(input logic cs, input logic r, input logic w,
                                input logic [1:0] sel, input logic [15:0] data);
      hpi_cs_n    = cs;
      hpi_r_n     = r;
      hpi_w_n     = w;
      hpi_address = sel;
      hpi_data_in = data;
   endtask

   // One host write: strobe for one cycle, then release
   task automatic hostWrite(input logic [1:0] sel, input logic [15:0] data);
      @(negedge clk_clk);
      applyStimulus(1'b0, 1'b1, 1'b0, sel, data);
      @(negedge clk_clk);
      applyStimulus(1'b1, 1'b1, 1'b1, sel, 16'h0000);
   endtask

   // One host read: strobe held two cycles so DATA reads have their result
   task automatic hostRead(input logic [1:0] sel, output logic [15:0] data);
      @(negedge clk_clk);
      applyStimulus(1'b0, 1'b0, 1'b1, sel, 16'h0000);
      @(negedge clk_clk);
      @(negedge clk_clk);
      data = hpi_data_out;
      applyStimulus(1'b1, 1'b1, 1'b1, sel, 16'h0000);
   endtask

   task automatic devMemWrite(input logic [MEM_AW-1:0] a, input logic [15:0] d);
      @(negedge clk_clk);
      dev_mem_we    = 1'b1;
      dev_mem_addr  = a;
      dev_mem_wdata = d;
      @(negedge clk_clk);
      dev_mem_we    = 1'b0;
   endtask

   task automatic devMbxPost(input logic [15:0] d);
      @(negedge clk_clk);
      dev_mbx_wr    = 1'b1;
      dev_mbx_wdata = d;
      @(negedge clk_clk);
      dev_mbx_wr    = 1'b0;
   endtask

   task automatic devMbxAck();
      @(negedge clk_clk);
      dev_mbx_ack = 1'b1;
      @(negedge clk_clk);
      dev_mbx_ack = 1'b0;
   endtask

   initial begin
      reset_reset_n = 1'b0;
      hpi_reset_n   = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b1, HPI_DATA, 16'h0000);
      dev_mem_we    = 1'b0;
      dev_mem_addr  = '0;
      dev_mem_wdata = '0;
      dev_mbx_wr    = 1'b0;
      dev_mbx_wdata = '0;
      dev_mbx_ack   = 1'b0;

      // Reset values
      repeat (3) @(negedge clk_clk);
      checkOutput("rst_data_out", hpi_data_out, 16'h0000);
      checkOutput("rst_int", {15'd0, hpi_int}, 16'h0000);
      checkOutput("rst_valid", {15'd0, dev_mbx_valid}, 16'h0000);
      checkOutput("rst_rdata", dev_mbx_rdata, 16'h0000);
      reset_reset_n = 1'b1;
      @(negedge clk_clk);
      hostRead(HPI_ADDRESS, rd);
      checkOutput("rst_addr", rd, 16'h0000);

      // Auto-increment on DATA writes, read back through the window
      hostWrite(HPI_ADDRESS, 16'h0100);
      hostWrite(HPI_DATA, 16'h1111);
      hostWrite(HPI_DATA, 16'h2222);
      hostRead(HPI_ADDRESS, rd);
      checkOutput("addr_after_wr", rd, 16'h0104);
      hostWrite(HPI_ADDRESS, 16'h0100);
      hostRead(HPI_DATA, rd);
      checkOutput("mem_80", rd, 16'h1111);
      hostRead(HPI_DATA, rd);
      checkOutput("mem_81", rd, 16'h2222);

      // Address wrap 0xFFFE -> 0x0000; word index aliases to 0xFFF
      devMemWrite(12'hFFF, 16'hA5A5);
      devMemWrite(12'h000, 16'h5A5A);
      hostWrite(HPI_ADDRESS, 16'hFFFE);
      hostRead(HPI_DATA, rd);
      checkOutput("wrap_top", rd, 16'hA5A5);
      hostRead(HPI_DATA, rd);
      checkOutput("wrap_zero", rd, 16'h5A5A);
      hostRead(HPI_ADDRESS, rd);
      checkOutput("wrap_addr", rd, 16'h0002);

      // Outbound mailbox
      devMbxPost(16'hBEEF);
      checkOutput("int_set", {15'd0, hpi_int}, 16'h0001);
      hostRead(HPI_STATUS, rd);
      checkOutput("status_out", rd, 16'h0001);
      hostRead(HPI_MAILBOX, rd);
      checkOutput("mbx_read", rd, 16'hBEEF);
      checkOutput("int_clr", {15'd0, hpi_int}, 16'h0000);

      // Inbound mailbox with overflow
      hostWrite(HPI_MAILBOX, 16'h0001);
      hostWrite(HPI_MAILBOX, 16'h0002);
      @(negedge clk_clk);
      checkOutput("in_valid", {15'd0, dev_mbx_valid}, 16'h0001);
      checkOutput("in_rdata", dev_mbx_rdata, 16'h0002);
      hostRead(HPI_STATUS, rd);
      checkOutput("status_ovf", rd, 16'h0102);
      hostRead(HPI_STATUS, rd);
      checkOutput("status_ovf_clr", rd, 16'h0100);
      devMbxAck();
      checkOutput("in_ack", {15'd0, dev_mbx_valid}, 16'h0000);

      // Long read strobe: exactly one increment
      hostWrite(HPI_ADDRESS, 16'h0010);
      @(negedge clk_clk);
      applyStimulus(1'b0, 1'b0, 1'b1, HPI_DATA, 16'h0000);
      repeat (20) @(negedge clk_clk);
      applyStimulus(1'b1, 1'b1, 1'b1, HPI_DATA, 16'h0000);
      hostRead(HPI_ADDRESS, rd);
      checkOutput("hold_once", rd, 16'h0012);

      // Both strobes low: no action
      @(negedge clk_clk);
      applyStimulus(1'b0, 1'b0, 1'b0, HPI_ADDRESS, 16'hDEAD);
      repeat (3) @(negedge clk_clk);
      applyStimulus(1'b0, 1'b0, 1'b0, HPI_MAILBOX, 16'hDEAD);
      repeat (3) @(negedge clk_clk);
      applyStimulus(1'b1, 1'b1, 1'b1, HPI_DATA, 16'h0000);
      checkOutput("illegal_valid", {15'd0, dev_mbx_valid}, 16'h0000);
      hostRead(HPI_ADDRESS, rd);
      checkOutput("illegal_addr", rd, 16'h0012);

      // Same-word host/device memory write: host wins
      hostWrite(HPI_ADDRESS, 16'h0200);
      @(negedge clk_clk);
      applyStimulus(1'b0, 1'b1, 1'b0, HPI_DATA, 16'hCAFE);
      dev_mem_we    = 1'b1;
      dev_mem_addr  = 12'h100;
      dev_mem_wdata = 16'h0BAD;
      @(negedge clk_clk);
      dev_mem_we = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b1, HPI_DATA, 16'h0000);
      hostWrite(HPI_ADDRESS, 16'h0200);
      hostRead(HPI_DATA, rd);
      checkOutput("mem_collide", rd, 16'hCAFE);

      // Device post colliding with host mailbox read
      devMbxPost(16'h1234);
      @(negedge clk_clk);
      applyStimulus(1'b0, 1'b0, 1'b1, HPI_MAILBOX, 16'h0000);
      dev_mbx_wr    = 1'b1;
      dev_mbx_wdata = 16'h5678;
      @(negedge clk_clk);
      dev_mbx_wr = 1'b0;
      checkOutput("mbx_old", hpi_data_out, 16'h1234);
      checkOutput("mbx_int_kept", {15'd0, hpi_int}, 16'h0001);
      @(negedge clk_clk);
      applyStimulus(1'b1, 1'b1, 1'b1, HPI_DATA, 16'h0000);
      hostRead(HPI_MAILBOX, rd);
      checkOutput("mbx_new", rd, 16'h5678);
      checkOutput("mbx_int_off", {15'd0, hpi_int}, 16'h0000);

      // Device ack colliding with host mailbox write
      hostWrite(HPI_MAILBOX, 16'h0022);
      @(negedge clk_clk);
      applyStimulus(1'b0, 1'b1, 1'b0, HPI_MAILBOX, 16'h0033);
      dev_mbx_ack = 1'b1;
      @(negedge clk_clk);
      dev_mbx_ack = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b1, HPI_DATA, 16'h0000);
      checkOutput("ack_full_kept", {15'd0, dev_mbx_valid}, 16'h0001);
      checkOutput("ack_rdata", dev_mbx_rdata, 16'h0033);
      hostRead(HPI_STATUS, rd);
      checkOutput("ack_status", rd, 16'h0102);

      // Soft reset in the middle of a DATA read
      devMbxPost(16'h7777);
      hostWrite(HPI_ADDRESS, 16'h0100);
      @(negedge clk_clk);
      applyStimulus(1'b0, 1'b0, 1'b1, HPI_DATA, 16'h0000);
      @(negedge clk_clk);
      hpi_reset_n = 1'b0;
      @(negedge clk_clk);
      checkOutput("srst_data_out", hpi_data_out, 16'h0000);
      checkOutput("srst_int", {15'd0, hpi_int}, 16'h0000);
      checkOutput("srst_valid", {15'd0, dev_mbx_valid}, 16'h0000);
      checkOutput("srst_rdata", dev_mbx_rdata, 16'h0000);
      hpi_reset_n = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b1, HPI_DATA, 16'h0000);
      hostRead(HPI_ADDRESS, rd);
      checkOutput("srst_addr", rd, 16'h0000);
      hostRead(HPI_STATUS, rd);
      checkOutput("srst_status", rd, 16'h0000);
      hostWrite(HPI_ADDRESS, 16'h0100);
      hostRead(HPI_DATA, rd);
      checkOutput("srst_mem_kept", rd, 16'h1111);

      repeat (2) @(negedge clk_clk);
      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
